// File: rtl/icache_line_buffer_pkg.sv
// Shared constants and state encoding for the single-line instruction fetch buffer.
package icache_line_buffer_pkg;

  localparam int         LINE_WORDS       = 4;
  localparam int         LINE_OFFSET_BITS = 4;
  localparam logic [2:0] RD_TYPE_LINE     = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS,
    S_REFILL,
    S_RESP
  } state_t;

  function automatic logic [31:0] line_base(input logic [31:0] addr);
    return {addr[31:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_line_buffer_if.sv
// Fetch-side (inst_sram) and bridge-side (icache rd/wr) signals of the line buffer.
interface icache_line_buffer_if;

  // A fetch transfers on inst_sram_req & inst_sram_addr_ok; inst_sram_data_ok is a
  // one-cycle pulse qualifying rdata. A refill transfers on icache_rd_req & icache_rd_rdy,
  // with req/addr held stable until then; every icache_ret_valid cycle is one beat.
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        flush;

  logic        icache_rd_req;
  logic [2:0]  icache_rd_type;
  logic [31:0] icache_rd_addr;
  logic        icache_rd_rdy;
  logic        icache_ret_valid;
  logic        icache_ret_last;
  logic [31:0] icache_ret_data;

  logic        icache_wr_req;
  logic [2:0]  icache_wr_type;
  logic [31:0] icache_wr_addr;
  logic [3:0]  icache_wr_wstrb;
  logic [31:0] icache_wr_data;

  modport slave (
    input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
           inst_sram_wstrb, inst_sram_wdata, flush,
           icache_rd_rdy, icache_ret_valid, icache_ret_last, icache_ret_data,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
           icache_rd_req, icache_rd_type, icache_rd_addr,
           icache_wr_req, icache_wr_type, icache_wr_addr, icache_wr_wstrb, icache_wr_data
  );

  modport master (
    output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
           inst_sram_wstrb, inst_sram_wdata, flush,
           icache_rd_rdy, icache_ret_valid, icache_ret_last, icache_ret_data,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
           icache_rd_req, icache_rd_type, icache_rd_addr,
           icache_wr_req, icache_wr_type, icache_wr_addr, icache_wr_wstrb, icache_wr_data
  );

endinterface

// File: rtl/icache_line_buffer.sv
// One-line instruction buffer: one-cycle hits, 4-beat line refill on a miss, never writes.
module icache_line_buffer
  import icache_line_buffer_pkg::*;
(
  input  logic                 aclk,
  input  logic                 areset,
  icache_line_buffer_if.slave  bus,
  output state_t               dbg_state,
  output logic                 dbg_valid
);

  state_t      state_q, state_d;
  logic        valid_q, valid_d;
  logic        drop_q, drop_d;
  logic [27:0] tag_q, tag_d;
  logic [31:0] line_q [LINE_WORDS];
  logic [31:0] line_d [LINE_WORDS];
  logic [31:0] req_addr_q, req_addr_d;
  logic [1:0]  beat_cnt_q, beat_cnt_d;

  logic hit;
  logic addr_ok;
  logic data_ok;
  logic rd_req;
  logic unused_inputs;

  assign hit     = (state_q == S_LOOKUP) && valid_q && (tag_q == req_addr_q[31:4]);
  // Gated by reset so every output reads 0 while areset is held.
  assign addr_ok = bus.inst_sram_req && !areset && ((state_q == S_IDLE) || hit);
  assign rd_req  = (state_q == S_MISS);

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    drop_d     = drop_q;
    tag_d      = tag_q;
    line_d     = line_q;
    req_addr_d = req_addr_q;
    beat_cnt_d = beat_cnt_q;
    data_ok    = 1'b0;

    if (addr_ok) req_addr_d = bus.inst_sram_addr;

    case (state_q)
      S_IDLE: begin
        if (bus.flush) valid_d = 1'b0;
        if (addr_ok) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (bus.flush) valid_d = 1'b0;
        if (hit) begin
          data_ok = 1'b1;
          state_d = addr_ok ? S_LOOKUP : S_IDLE;
        end else begin
          state_d = S_MISS;
        end
      end
      S_MISS: begin
        if (bus.flush) drop_d = 1'b1;
        if (bus.icache_rd_rdy) begin
          state_d    = S_REFILL;
          beat_cnt_d = 2'd0;
        end
      end
      S_REFILL: begin
        if (bus.flush) drop_d = 1'b1;
        if (bus.icache_ret_valid) begin
          line_d[beat_cnt_q] = bus.icache_ret_data;
          beat_cnt_d         = beat_cnt_q + 2'd1;
          // A flush seen at any point of the burst leaves the filled line invalid.
          if (bus.icache_ret_last) begin
            tag_d   = req_addr_q[31:4];
            valid_d = ~(drop_q | bus.flush);
            drop_d  = 1'b0;
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        data_ok = 1'b1;
        if (bus.flush) valid_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= S_IDLE;
      valid_q    <= 1'b0;
      drop_q     <= 1'b0;
      tag_q      <= '0;
      line_q     <= '{default: '0};
      req_addr_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      drop_q     <= drop_d;
      tag_q      <= tag_d;
      line_q     <= line_d;
      req_addr_q <= req_addr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign bus.inst_sram_addr_ok = addr_ok;
  assign bus.inst_sram_data_ok = data_ok;
  assign bus.inst_sram_rdata   = data_ok ? line_q[req_addr_q[3:2]] : 32'h0;

  assign bus.icache_rd_req  = rd_req;
  assign bus.icache_rd_type = rd_req ? RD_TYPE_LINE : 3'b000;
  assign bus.icache_rd_addr = rd_req ? line_base(req_addr_q) : 32'h0;

  assign bus.icache_wr_req   = 1'b0;
  assign bus.icache_wr_type  = 3'b000;
  assign bus.icache_wr_addr  = 32'h0;
  assign bus.icache_wr_wstrb = 4'h0;
  assign bus.icache_wr_data  = 32'h0;

  assign dbg_state = state_q;
  assign dbg_valid = valid_q;

  assign unused_inputs = ^{bus.inst_sram_wr, bus.inst_sram_size, bus.inst_sram_wstrb,
                           bus.inst_sram_wdata, req_addr_q[1:0]};

endmodule

// File: tb/tb_icache_line_buffer.sv
// Bench for icache_line_buffer: directed scenarios plus randomized fetch/flush traffic.
module tb_icache_line_buffer;
  import icache_line_buffer_pkg::*;

  // ---------------- clock / reset ----------------
  logic   aclk = 1'b0;
  logic   areset;
  state_t dbg_state;
  logic   dbg_valid;

  icache_line_buffer_if bus();

  icache_line_buffer dut (
    .aclk      (aclk),
    .areset    (areset),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_valid (dbg_valid)
  );

  always #5 aclk = ~aclk;

  // ---------------- bookkeeping ----------------
  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Backing memory seen through the bridge; line 0x1c000000 holds 0x11,0x22,0x33,0x44.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] k;
    if (a[31:4] == 28'h1c00000) begin
      k = {30'b0, a[3:2]} + 32'd1;
      return k * 32'h11;
    end
    return {a[15:0], ~a[15:0]} ^ 32'h5a5a_0000;
  endfunction

  // ---------------- bridge model ----------------
  int          stall_cycles = 0;
  bit          rand_bridge  = 1'b0;
  int          beats_left   = 0;
  int          bidx         = 0;
  logic [31:0] baddr        = '0;

  initial begin
    logic        ar_hs, beat_hs;
    logic [31:0] ar_a;
    bus.icache_rd_rdy    = 1'b0;
    bus.icache_ret_valid = 1'b0;
    bus.icache_ret_last  = 1'b0;
    bus.icache_ret_data  = '0;
    forever begin
      @(negedge aclk);
      ar_hs   = bus.icache_rd_req && bus.icache_rd_rdy;
      ar_a    = bus.icache_rd_addr;
      beat_hs = bus.icache_ret_valid;
      @(posedge aclk);
      #1;
      if (areset) begin
        beats_left           = 0;
        bidx                 = 0;
        bus.icache_rd_rdy    = 1'b0;
        bus.icache_ret_valid = 1'b0;
        bus.icache_ret_last  = 1'b0;
      end else begin
        if (beat_hs && beats_left > 0) begin
          beats_left--;
          bidx++;
        end
        if (ar_hs) begin
          beats_left = 4;
          bidx       = 0;
          baddr      = ar_a;
        end
        if (bus.icache_rd_req) begin
          if (stall_cycles > 0) begin
            stall_cycles--;
            bus.icache_rd_rdy = 1'b0;
          end else begin
            bus.icache_rd_rdy = rand_bridge ? ($urandom_range(0, 2) != 0) : 1'b1;
          end
        end else begin
          bus.icache_rd_rdy = 1'b0;
        end
        if (beats_left > 0 && (!rand_bridge || $urandom_range(0, 2) != 0)) begin
          bus.icache_ret_valid = 1'b1;
          bus.icache_ret_last  = (beats_left == 1);
          bus.icache_ret_data  = mem_word(baddr + 32'(4 * bidx));
        end else begin
          bus.icache_ret_valid = 1'b0;
          bus.icache_ret_last  = 1'b0;
          bus.icache_ret_data  = $urandom;
        end
      end
    end
  end

  // ---------------- reference model + scoreboard ----------------
  // Transaction-level view: at most one fetch outstanding; a fetch is either in its
  // lookup cycle or waiting on a refill. The line is tracked as valid + tag only,
  // data always comes from mem_word().
  logic [31:0] exp_q[$];
  logic [31:0] got_log[$];
  bit          m_valid = 1'b0, m_drop = 1'b0;
  logic [27:0] m_tag   = '0;
  bit          pend = 1'b0, in_lookup = 1'b0, ar_done = 1'b0, fill_done = 1'b0;
  logic [31:0] pend_addr = '0;
  int          ar_count = 0, rdreq_cycles = 0, resp_count = 0, beat_count = 0;
  logic [31:0] last_ar_addr = '0;

  bit lookup_hit, resp_now, exp_addr_ok, exp_data_ok, exp_rd_req, fill_now;

  always @(negedge aclk) begin
    if (areset) begin
      check("rst_ctrl", {28'b0, bus.inst_sram_addr_ok, bus.inst_sram_data_ok,
                         bus.icache_rd_req, bus.icache_wr_req}, 32'h0);
      check("rst_rdata", bus.inst_sram_rdata, 32'h0);
      check("rst_rd_addr", bus.icache_rd_addr, 32'h0);
      check("rst_state", {29'b0, dbg_state}, {29'b0, S_IDLE});
      check("rst_valid", {31'b0, dbg_valid}, 32'h0);
      pend = 1'b0; in_lookup = 1'b0; ar_done = 1'b0; fill_done = 1'b0;
      m_valid = 1'b0; m_drop = 1'b0;
      exp_q.delete();
    end else begin
      lookup_hit  = pend && in_lookup && m_valid && (m_tag == pend_addr[31:4]);
      resp_now    = pend && !in_lookup && fill_done;
      exp_addr_ok = bus.inst_sram_req && (!pend || lookup_hit);
      exp_data_ok = lookup_hit || resp_now;
      exp_rd_req  = pend && !in_lookup && !ar_done;

      check("addr_ok", {31'b0, bus.inst_sram_addr_ok}, {31'b0, exp_addr_ok});
      check("data_ok", {31'b0, bus.inst_sram_data_ok}, {31'b0, exp_data_ok});
      check("rd_req", {31'b0, bus.icache_rd_req}, {31'b0, exp_rd_req});
      check("wr_idle", {31'b0, |{bus.icache_wr_req, bus.icache_wr_type, bus.icache_wr_addr,
                                bus.icache_wr_wstrb, bus.icache_wr_data}}, 32'h0);
      if (exp_rd_req) begin
        check("rd_addr", bus.icache_rd_addr, {pend_addr[31:4], 4'b0});
        check("rd_type", {29'b0, bus.icache_rd_type}, 32'h4);
      end
      if (exp_data_ok) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL rdata_queue: got a response, expected queue empty (t=%0t)", $time);
        end else begin
          check("rdata", bus.inst_sram_rdata, exp_q.pop_front());
        end
        got_log.push_back(bus.inst_sram_rdata);
        resp_count++;
      end

      if (bus.icache_rd_req) rdreq_cycles++;
      if (bus.icache_rd_req && bus.icache_rd_rdy) begin
        ar_count++;
        last_ar_addr = bus.icache_rd_addr;
      end
      if (bus.icache_ret_valid) beat_count++;

      fill_now = pend && !in_lookup && ar_done && !fill_done &&
                 bus.icache_ret_valid && bus.icache_ret_last;
      if (bus.flush) begin
        if (!pend || in_lookup || resp_now) m_valid = 1'b0;
        else m_drop = 1'b1;
      end
      if (fill_now) begin
        m_tag     = pend_addr[31:4];
        m_valid   = !(m_drop || bus.flush);
        m_drop    = 1'b0;
        fill_done = 1'b1;
      end
      if (exp_rd_req && bus.icache_rd_rdy) ar_done = 1'b1;

      if (!pend || (in_lookup && lookup_hit) || resp_now) begin
        pend = 1'b0;
        if (exp_addr_ok) begin
          pend      = 1'b1;
          in_lookup = 1'b1;
          pend_addr = bus.inst_sram_addr;
          exp_q.push_back(mem_word(bus.inst_sram_addr));
        end
      end else if (in_lookup) begin
        in_lookup = 1'b0;
        ar_done   = 1'b0;
        fill_done = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [31:0] a);
    int n;
    bit ok;
    bus.inst_sram_req  = 1'b1;
    bus.inst_sram_addr = a;
    n = 0;
    forever begin
      @(negedge aclk);
      ok = bus.inst_sram_addr_ok;
      if (ok) break;
      n++;
      if (n > 200) begin
        vectors++;
        miscompares++;
        $display("FAIL issue_timeout: addr %h got no addr_ok, expected one within 200 cycles", a);
        break;
      end
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic idle();
    bus.inst_sram_req  = 1'b0;
    bus.inst_sram_addr = $urandom;
  endtask

  task automatic wait_resp(input int target);
    int n;
    n = 0;
    while (resp_count < target && n < 200) begin
      @(posedge aclk);
      n++;
    end
    if (resp_count < target) begin
      vectors++;
      miscompares++;
      $display("FAIL resp_timeout: got %0d responses, expected %0d", resp_count, target);
    end
    #1;
  endtask

  task automatic fetch(input logic [31:0] a);
    int t;
    t = resp_count + 1;
    issue(a);
    idle();
    wait_resp(t);
  endtask

  task automatic wait_beats(input int target);
    int n;
    n = 0;
    while (beat_count < target && n < 200) begin
      @(posedge aclk);
      n++;
    end
    if (beat_count < target) begin
      vectors++;
      miscompares++;
      $display("FAIL beat_timeout: got %0d beats, expected %0d", beat_count, target);
    end
  endtask

  // ---------------- stimulus ----------------
  bit rand_stop = 1'b0;

  initial begin
    int a0, r0, q0, b0;
    logic [31:0] a;
    areset              = 1'b1;
    bus.inst_sram_req   = 1'b0;
    bus.inst_sram_wr    = 1'b0;
    bus.inst_sram_size  = 2'd2;
    bus.inst_sram_addr  = '0;
    bus.inst_sram_wstrb = '0;
    bus.inst_sram_wdata = '0;
    bus.flush           = 1'b0;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    repeat (2) @(posedge aclk);
    #1;

    // cold miss
    fetch(32'h1c00_0008);
    check("cold_rdata", got_log[got_log.size()-1], 32'h33);
    check("cold_ar_count", ar_count, 1);
    check("cold_ar_addr", last_ar_addr, 32'h1c00_0000);
    check("cold_valid", {31'b0, dbg_valid}, 32'h1);

    // back-to-back hits
    a0 = ar_count;
    r0 = resp_count;
    issue(32'h1c00_0000);
    issue(32'h1c00_0004);
    issue(32'h1c00_000c);
    idle();
    wait_resp(r0 + 3);
    check("b2b_w0", got_log[r0], 32'h11);
    check("b2b_w1", got_log[r0+1], 32'h22);
    check("b2b_w3", got_log[r0+2], 32'h44);
    check("b2b_no_refill", ar_count, a0);

    // tag mismatch, then the old line misses again
    fetch(32'h1c00_0010);
    check("tag_ar_count", ar_count, a0 + 1);
    check("tag_ar_addr", last_ar_addr, 32'h1c00_0010);
    fetch(32'h1c00_0000);
    check("old_line_ar_count", ar_count, a0 + 2);
    check("old_line_rdata", got_log[got_log.size()-1], 32'h11);

    // bridge stalls rd_rdy for 5 cycles
    a0 = ar_count;
    q0 = rdreq_cycles;
    stall_cycles = 5;
    fetch(32'h1c00_0024);
    check("stall_ar_count", ar_count, a0 + 1);
    check("stall_rdreq_cycles", rdreq_cycles - q0, 6);
    check("stall_ar_addr", last_ar_addr, 32'h1c00_0020);

    // flush while beat 2 is delivered
    a0 = ar_count;
    r0 = resp_count;
    b0 = beat_count;
    issue(32'h1c00_0008);
    idle();
    wait_beats(b0 + 1);
    #1 bus.flush = 1'b1;
    @(posedge aclk);
    #1 bus.flush = 1'b0;
    wait_resp(r0 + 1);
    check("flush_rdata", got_log[got_log.size()-1], 32'h33);
    check("flush_line_invalid", {31'b0, dbg_valid}, 32'h0);
    fetch(32'h1c00_0008);
    check("flush_refetch_ar", ar_count, a0 + 2);

    // reset in the middle of a refill
    a0 = ar_count;
    b0 = beat_count;
    issue(32'h1c00_0034);
    idle();
    wait_beats(b0 + 2);
    #3 areset = 1'b1;
    #1;
    check("arst_ctrl", {29'b0, bus.inst_sram_data_ok, bus.icache_rd_req, bus.inst_sram_addr_ok}, 32'h0);
    check("arst_rdata", bus.inst_sram_rdata, 32'h0);
    check("arst_state", {29'b0, dbg_state}, {29'b0, S_IDLE});
    check("arst_valid", {31'b0, dbg_valid}, 32'h0);
    @(posedge aclk);
    @(posedge aclk);
    #1 areset = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    fetch(32'h1c00_0000);
    check("post_reset_miss", ar_count, a0 + 2);
    check("post_reset_rdata", got_log[got_log.size()-1], 32'h11);

    // randomized traffic with random flushes and bridge timing
    rand_bridge = 1'b1;
    fork
      begin
        while (!rand_stop) begin
          @(posedge aclk);
          #1 bus.flush = ($urandom_range(0, 15) == 0);
        end
        bus.flush = 1'b0;
      end
    join_none
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0:       a = 32'h1c00_0000;
        1:       a = 32'h1c00_0010;
        2:       a = 32'h1c00_0100;
        default: a = 32'h3c00_0000;
      endcase
      a[3:2] = 2'($urandom_range(0, 3));
      issue(a);
      if ($urandom_range(0, 1) == 0) begin
        idle();
        repeat ($urandom_range(0, 2)) @(posedge aclk);
        #1;
      end
    end
    idle();
    rand_stop = 1'b1;
    repeat (80) @(posedge aclk);
    #1;
    check("drain_exp_q", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion before 500us");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
